// File: rtl/bg_line_fetcher_if.sv
// Bundles the VRAM read port and the pixel stream of the background line fetcher.
`timescale 1ns/1ps
interface bg_line_fetcher_if #(
    parameter int ADDR_W = 13
);
    logic              vram_rd;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_rdata;
    logic              pix_valid;
    logic              pix_ready;
    logic [1:0]        pix_shade;
    logic [7:0]        pix_x;

    modport master (
        output vram_rd, vram_addr,
        input  vram_rdata,
        output pix_valid, pix_shade, pix_x,
        input  pix_ready
    );

    modport slave (
        input  vram_rd, vram_addr,
        output vram_rdata,
        input  pix_valid, pix_shade, pix_x,
        output pix_ready
    );
endinterface

// File: rtl/bg_line_fetcher.sv
// Fetches one scrolled background scanline from VRAM (map, then tile row bytes)
// and streams palette-mapped 2-bit shades over a valid/ready handshake.
`timescale 1ns/1ps
module bg_line_fetcher #(
    parameter int LINE_WIDTH = 160,
    parameter int ADDR_W     = 13
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [7:0]         ly,
    input  logic [7:0]         scx,
    input  logic [7:0]         scy,
    input  logic               map_sel,
    input  logic               tile_sel,
    input  logic [7:0]         bgp,
    bg_line_fetcher_if.master  bus,
    output logic               busy,
    output logic               line_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAP,
        S_LO,
        S_HI,
        S_PUSH,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  y_q, y_d;
    logic [7:0]  scx_q, scx_d;
    logic        msel_q, msel_d;
    logic        tsel_q, tsel_d;
    logic [7:0]  bgp_q, bgp_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic        hcap_q, hcap_d;
    logic [4:0]  n_q, n_d;
    logic [2:0]  p_q, p_d;
    logic        first_q, first_d;
    logic [7:0]  x_q, x_d;

    logic [4:0]  col;
    logic [15:0] map_full;
    logic [15:0] lo_full;
    logic [15:0] hi_full;
    logic [7:0]  hi_cur;
    logic [1:0]  color;
    logic [1:0]  shade;
    logic        discard;
    logic        last_pix;

    // Tile row address: unsigned tiles from 0x0000, or signed index around 0x1000.
    function automatic logic [15:0] tile_addr(input logic [7:0] idx,
                                              input logic       tsel,
                                              input logic [2:0] trow,
                                              input logic       upper);
        logic signed [15:0] sidx;
        logic        [15:0] base;
        sidx = {{8{idx[7]}}, idx};
        if (tsel)
            base = {4'b0, idx, 4'b0};
        else
            base = 16'sh1000 + (sidx <<< 4);
        return base + {12'b0, trow, 1'b0} + {15'b0, upper};
    endfunction

    function automatic logic [1:0] palette_map(input logic [7:0] pal,
                                               input logic [1:0] c);
        return pal[{c, 1'b1} -: 2];
    endfunction

    assign col      = scx_q[7:3] + n_q;
    assign map_full = (msel_q ? 16'h1C00 : 16'h1800) + {6'b0, y_q[7:3], 5'b0} + {11'b0, col};
    assign lo_full  = tile_addr(bus.vram_rdata, tsel_q, y_q[2:0], 1'b0);
    assign hi_full  = tile_addr(idx_q, tsel_q, y_q[2:0], 1'b1);

    // The high byte lands on the bus during the first PUSH cycle; use it directly then.
    assign hi_cur   = hcap_q ? bus.vram_rdata : hi_q;
    assign color    = {hi_cur[~p_q], lo_q[~p_q]};
    assign shade    = palette_map(bgp_q, color);
    assign discard  = first_q && (p_q < scx_q[2:0]);
    assign last_pix = (x_q == 8'(LINE_WIDTH - 1));

    always_comb begin
        state_d       = state_q;
        y_d           = y_q;
        scx_d         = scx_q;
        msel_d        = msel_q;
        tsel_d        = tsel_q;
        bgp_d         = bgp_q;
        idx_d         = idx_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        hcap_d        = hcap_q;
        n_d           = n_q;
        p_d           = p_q;
        first_d       = first_q;
        x_d           = x_q;
        bus.vram_rd   = 1'b0;
        bus.vram_addr = '0;
        bus.pix_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    y_d     = ly + scy;
                    scx_d   = scx;
                    msel_d  = map_sel;
                    tsel_d  = tile_sel;
                    bgp_d   = bgp;
                    n_d     = '0;
                    p_d     = '0;
                    first_d = 1'b1;
                    hcap_d  = 1'b0;
                    x_d     = '0;
                    state_d = S_MAP;
                end
            end
            S_MAP: begin
                bus.vram_rd   = 1'b1;
                bus.vram_addr = map_full[ADDR_W-1:0];
                state_d       = S_LO;
            end
            S_LO: begin
                idx_d         = bus.vram_rdata;
                bus.vram_rd   = 1'b1;
                bus.vram_addr = lo_full[ADDR_W-1:0];
                state_d       = S_HI;
            end
            S_HI: begin
                lo_d          = bus.vram_rdata;
                bus.vram_rd   = 1'b1;
                bus.vram_addr = hi_full[ADDR_W-1:0];
                hcap_d        = 1'b1;
                state_d       = S_PUSH;
            end
            S_PUSH: begin
                hi_d          = hi_cur;
                hcap_d        = 1'b0;
                bus.pix_valid = !discard;
                if (discard || bus.pix_ready) begin
                    if (!discard && last_pix) begin
                        state_d = S_DONE;
                    end else begin
                        if (!discard)
                            x_d = x_q + 8'd1;
                        if (p_q == 3'd7) begin
                            p_d     = '0;
                            n_d     = n_q + 5'd1;
                            first_d = 1'b0;
                            state_d = S_MAP;
                        end else begin
                            p_d = p_q + 3'd1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.pix_shade = bus.pix_valid ? shade : 2'b00;
    assign bus.pix_x     = x_q;
    assign busy          = (state_q != S_IDLE);
    assign line_done     = (state_q == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            hcap_q  <= 1'b0;
            n_q     <= '0;
            p_q     <= '0;
            first_q <= 1'b0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            hcap_q  <= hcap_d;
            n_q     <= n_d;
            p_q     <= p_d;
            first_q <= first_d;
            x_q     <= x_d;
        end
    end

    // Latched line parameters and fetched bytes are only read once qualified by state.
    always_ff @(posedge clk) begin
        y_q    <= y_d;
        scx_q  <= scx_d;
        msel_q <= msel_d;
        tsel_q <= tsel_d;
        bgp_q  <= bgp_d;
        idx_q  <= idx_d;
        lo_q   <= lo_d;
        hi_q   <= hi_d;
    end

endmodule

// File: tb/tb_bg_line_fetcher.sv
// Directed and randomized line fetches checked against a per-pixel VRAM lookup model.
`timescale 1ns/1ps
module tb_bg_line_fetcher;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] ly = 8'h00, scx = 8'h00, scy = 8'h00, bgp = 8'h00;
    logic       map_sel = 1'b0, tile_sel = 1'b1;
    logic       busy, line_done;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:8191];
    logic [12:0] rd_log [$];
    logic [1:0]  got [0:159];
    int          busy_cyc;

    bg_line_fetcher_if #(.ADDR_W(13)) vif ();

    bg_line_fetcher #(.LINE_WIDTH(160), .ADDR_W(13)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .ly        (ly),
        .scx       (scx),
        .scy       (scy),
        .map_sel   (map_sel),
        .tile_sel  (tile_sel),
        .bgp       (bgp),
        .bus       (vif),
        .busy      (busy),
        .line_done (line_done)
    );

    always #5 clk = ~clk;

    // VRAM: data one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        vif.vram_rdata <= vif.vram_rd ? mem[vif.vram_addr] : 8'($urandom);
        if (vif.vram_rd) rd_log.push_back(vif.vram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Screen pixel x of a line: follow the scrolled coordinate through map, tile and palette.
    function automatic int model_shade(int x, int lyv, int scxv, int scyv, int msel, int tsel, int bgpv);
        int y, sx, addr, idx, sidx, tbase, lo, hi, p, c;
        y    = (lyv + scyv) % 256;
        sx   = (scxv + x) % 256;
        addr = (msel != 0 ? 'h1C00 : 'h1800) + (y / 8) * 32 + (sx / 8);
        idx  = int'(mem[13'(addr)]);
        sidx = (idx >= 128) ? idx - 256 : idx;
        tbase = (tsel != 0) ? idx * 16 : 4096 + sidx * 16;
        tbase = tbase + (y % 8) * 2;
        lo   = int'(mem[13'(tbase)]);
        hi   = int'(mem[13'(tbase + 1)]);
        p    = sx % 8;
        c    = (((hi >> (7 - p)) & 1) * 2) + ((lo >> (7 - p)) & 1);
        return (bgpv >> (2 * c)) & 3;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rd"},    32'(vif.vram_rd),   32'd0);
        chk({tag, "_addr"},  32'(vif.vram_addr), 32'd0);
        chk({tag, "_valid"}, 32'(vif.pix_valid), 32'd0);
        chk({tag, "_shade"}, 32'(vif.pix_shade), 32'd0);
        chk({tag, "_x"},     32'(vif.pix_x),     32'd0);
        chk({tag, "_busy"},  32'(busy),          32'd0);
        chk({tag, "_done"},  32'(line_done),     32'd0);
    endtask

    task automatic run_line(input int lyv, input int scxv, input int scyv, input int msel,
                            input int tsel, input int bgpv, input int duty, input int abort_at,
                            input string tag);
        int  acc = 0, cyc = 0, f, tiles, exp_cyc;
        bit  held = 0, seen_done = 0;
        logic [1:0] h_shade;
        logic [7:0] h_x;
        rd_log.delete();
        busy_cyc = 0;
        @(negedge clk);
        ly = 8'(lyv); scx = 8'(scxv); scy = 8'(scyv);
        map_sel = msel[0]; tile_sel = tsel[0]; bgp = 8'(bgpv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ly = 8'($urandom); scx = 8'($urandom); scy = 8'($urandom);
        map_sel = 1'($urandom); tile_sel = 1'($urandom); bgp = 8'($urandom);
        while (cyc < 6000) begin
            vif.pix_ready = (int'($urandom_range(99)) < duty);
            #1;
            if (held) begin
                chk({tag, "_hold_valid"}, 32'(vif.pix_valid), 32'd1);
                chk({tag, "_hold_shade"}, 32'(vif.pix_shade), 32'(h_shade));
                chk({tag, "_hold_x"},     32'(vif.pix_x),     32'(h_x));
                held = 0;
            end
            if (line_done) begin
                seen_done = 1;
                start = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
            if (vif.pix_valid) begin
                if (vif.pix_ready) begin
                    chk({tag, "_x"}, 32'(vif.pix_x), 32'(acc));
                    if (acc < 160) begin
                        chk({tag, "_shade"}, 32'(vif.pix_shade),
                            32'(model_shade(acc, lyv, scxv, scyv, msel, tsel, bgpv)));
                        got[acc] = vif.pix_shade;
                    end
                    acc++;
                    if (acc == abort_at) begin
                        @(negedge clk);
                        reset_n = 1'b0;
                        #1;
                        check_reset_vals({tag, "_rst"});
                        repeat (3) begin
                            @(negedge clk);
                            #1;
                            chk({tag, "_rst_nodone"}, 32'(line_done), 32'd0);
                        end
                        reset_n = 1'b1;
                        vif.pix_ready = 1'b0;
                        return;
                    end
                end else begin
                    held = 1;
                    h_shade = vif.pix_shade;
                    h_x = vif.pix_x;
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_line_done_seen"}, 32'(seen_done), 32'd1);
        chk({tag, "_npix"}, 32'(acc), 32'd160);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_done_once"},  32'(line_done), 32'd0);
        if (duty >= 100) begin
            f = scxv % 8;
            tiles = (160 + f + 7) / 8;
            exp_cyc = tiles * 11 - (tiles * 8 - (160 + f));
            chk({tag, "_cycles"}, 32'(busy_cyc), 32'(exp_cyc));
        end
        vif.pix_ready = 1'b0;
    endtask

    initial begin
        int mrow;
        vif.pix_ready = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;

        #12;
        check_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Solid colour 1 across the whole line.
        for (int i = 'h1800; i < 'h1C00; i++) mem[i] = 8'h01;
        mem[16] = 8'hFF; mem[17] = 8'h00;
        run_line(0, 0, 0, 0, 1, 'hE4, 100, -1, "t1");
        chk("t1_first", 32'(got[0]), 32'd1);
        chk("t1_last",  32'(got[159]), 32'd1);

        // Four-shade repeating pattern.
        mem[16] = 8'h55; mem[17] = 8'h33;
        run_line(0, 0, 0, 0, 1, 'h1B, 100, -1, "t2");
        chk("t2_p0", 32'(got[0]), 32'd3);
        chk("t2_p1", 32'(got[1]), 32'd2);
        chk("t2_p2", 32'(got[2]), 32'd1);
        chk("t2_p3", 32'(got[3]), 32'd0);
        chk("t2_p4", 32'(got[4]), 32'd3);

        // Fine scroll of 3 across a tile boundary.
        mem[16] = 8'hFF; mem[17] = 8'h00;
        mem[32] = 8'h00; mem[33] = 8'hFF;
        mem['h1801] = 8'h02;
        run_line(0, 3, 0, 0, 1, 'hE4, 100, -1, "t3");
        chk("t3_x0", 32'(got[0]), 32'd1);
        chk("t3_x4", 32'(got[4]), 32'd1);
        chk("t3_x5", 32'(got[5]), 32'd2);

        // Signed tile indexing at both extremes.
        for (int i = 'h1800; i < 'h1C00; i++) mem[i] = 8'h80;
        mem['h1801] = 8'h7F;
        mem['h0800] = 8'hA5; mem['h0801] = 8'h3C;
        mem['h17F0] = 8'h0F; mem['h17F1] = 8'hF0;
        run_line(0, 0, 0, 0, 0, 'hE4, 100, -1, "t4");
        chk("t4_map0", 32'(rd_log[0]), 32'h1800);
        chk("t4_lo80", 32'(rd_log[1]), 32'h0800);
        chk("t4_hi80", 32'(rd_log[2]), 32'h0801);
        chk("t4_map1", 32'(rd_log[3]), 32'h1801);
        chk("t4_lo7f", 32'(rd_log[4]), 32'h17F0);

        // Map column wrap with vertical wrap of ly+scy.
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        mrow = ((8'hF0 + 8'h20) % 256) / 8;
        run_line('hF0, 'hF8, 'h20, 0, 1, 'hE4, 100, -1, "t5");
        chk("t5_map_col31", 32'(rd_log[0]), 32'('h1800 + mrow * 32 + 31));
        chk("t5_map_col0",  32'(rd_log[3]), 32'('h1800 + mrow * 32));

        // Backpressure, mid-line reset, then recovery and random configurations.
        run_line(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)),
                 1, 0, int'($urandom_range(255)), 30, -1, "t6a");
        run_line(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)),
                 0, 1, int'($urandom_range(255)), 30, 50, "t6b");
        run_line(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)),
                 int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(255)),
                 60, -1, "t6c");
        for (int k = 0; k < 3; k++) begin
            run_line(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)),
                     int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(255)),
                     (k == 0) ? 100 : int'($urandom_range(20, 90)), -1, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
